// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: one pattern table for both the display encoder and the
// scan-bus decoder, so the two sides can never disagree on a glyph.
package seven_seg_pkg;

  localparam int SEG_DP_BIT = 7;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Segment order is a..g on bits 6..0, active-high.
  localparam logic [6:0] SEG_HEX_0 = 7'h7E;
  localparam logic [6:0] SEG_HEX_1 = 7'h30;
  localparam logic [6:0] SEG_HEX_2 = 7'h6D;
  localparam logic [6:0] SEG_HEX_3 = 7'h79;
  localparam logic [6:0] SEG_HEX_4 = 7'h33;
  localparam logic [6:0] SEG_HEX_5 = 7'h5B;
  localparam logic [6:0] SEG_HEX_6 = 7'h5F;
  localparam logic [6:0] SEG_HEX_7 = 7'h72;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h7B;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h1F;
  localparam logic [6:0] SEG_HEX_C = 7'h4E;
  localparam logic [6:0] SEG_HEX_D = 7'h3D;
  localparam logic [6:0] SEG_HEX_E = 7'h4F;
  localparam logic [6:0] SEG_HEX_F = 7'h47;

  localparam logic [15:0][6:0] SEG_HEX_TABLE = {
    SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
    SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
    SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
    SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
  };

  // Outcome of classifying one committed segment pattern.
  typedef enum logic [1:0] {
    PAT_HIT   = 2'd0,
    PAT_BLANK = 2'd1,
    PAT_BAD   = 2'd2
  } pat_kind_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] hex);
    return SEG_HEX_TABLE[hex];
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational reverse lookup of a 7-segment pattern to its hex digit.
// Exactly one of hit_o / blank_o is set for recognised patterns; neither for garbage.
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       hit_o,
  output logic       blank_o,
  output logic [3:0] hex_o
);

  // NOTE: every output gets a default before the table search; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    hit_o   = 1'b0;
    blank_o = (seg_i == SEG_BLANK);
    hex_o   = 4'h0;
    for (int h = 0; h < 16; h++) begin
      if (seg_i == SEG_HEX_TABLE[h]) begin
        hit_o = 1'b1;
        hex_o = 4'(h);
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: synchronises, debounces the scan, and
// rebuilds the hex value, dp and validity of each digit, plus scan-health flags.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   bad_pattern,
  output logic                    upd_stb,
  output logic [IDX_W-1:0]        upd_idx,
  output logic                    frame_stb,
  output logic                    sel_err
);

  localparam int SW    = 8 + NUM_DIGITS;
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  // ---------------------------------------------------------------- synchroniser
  logic [SW-1:0] s_raw;
  logic [SW-1:0] s_sync;

  assign s_raw = {seg_in, dig_sel};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_sync = s_raw;
    end else begin : g_sync
      logic [SW-1:0] sync_q [SYNC_STAGES];

      // NOTE: clocked state uses non-blocking assignments so every register sees the
      // pre-edge value of its neighbours; reset is sampled on the clock edge.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= s_raw;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign s_sync = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------- stability tracking
  logic [SW-1:0]    s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             changed;
  logic             at_thresh;
  logic             first_thresh;

  assign changed      = (s_sync != s_q);
  assign at_thresh    = (cnt_q == CNT_MAX);
  // First cycle of a stable interval at which the threshold is reached.
  assign first_thresh = at_thresh && !done_q;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (changed) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (at_thresh) begin
      done_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------- sample decode
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] dig_q;
  logic                  one_hot;
  logic                  multi_hot;
  logic                  commit;
  logic [IDX_W-1:0]      dig_idx;
  logic                  dec_hit;
  logic                  dec_blank;
  logic [3:0]            dec_hex;
  pat_kind_e             kind;

  assign seg_q     = s_q[SW-1 -: 8];
  assign dig_q     = s_q[NUM_DIGITS-1:0];
  assign one_hot   = ($countones(dig_q) == 1);
  assign multi_hot = ($countones(dig_q) > 1);
  assign commit    = first_thresh && one_hot;

  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_q[i]) dig_idx = IDX_W'(i);
    end
  end

  seg_pattern_decode u_decode (
    .seg_i   (seg_q[6:0]),
    .hit_o   (dec_hit),
    .blank_o (dec_blank),
    .hex_o   (dec_hex)
  );

  always_comb begin
    if (dec_hit)        kind = PAT_HIT;
    else if (dec_blank) kind = PAT_BLANK;
    else                kind = PAT_BAD;
  end

  // ---------------------------------------------------------------- per-digit state
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   bad_q, bad_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [NUM_DIGITS-1:0]   seen_nx;
  logic                    upd_stb_q, upd_stb_d;
  logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;
  logic                    frame_q, frame_d;
  logic                    sel_err_q, sel_err_d;

  // clr wipes the status bits first; a commit in the same cycle then lands on top.
  always_comb begin
    hex_d     = hex_q;
    dp_d      = dp_q;
    valid_d   = clr ? '0 : valid_q;
    bad_d     = clr ? '0 : bad_q;
    sel_err_d = (clr ? 1'b0 : sel_err_q) | (first_thresh && multi_hot);
    upd_stb_d = commit;
    upd_idx_d = commit ? dig_idx : upd_idx_q;
    seen_nx   = (clr ? '0 : seen_q) | (commit ? dig_q : '0);
    frame_d   = &seen_nx;
    seen_d    = frame_d ? '0 : seen_nx;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (commit && dig_q[i]) begin
        dp_d[i] = seg_q[SEG_DP_BIT];
        unique case (kind)
          PAT_HIT: begin
            hex_d[4*i +: 4] = dec_hex;
            valid_d[i]      = 1'b1;
            bad_d[i]        = 1'b0;
          end
          PAT_BLANK: begin
            valid_d[i] = 1'b0;
            bad_d[i]   = 1'b0;
          end
          default: begin
            valid_d[i] = 1'b0;
            bad_d[i]   = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q       <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      hex_q     <= '0;
      dp_q      <= '0;
      valid_q   <= '0;
      bad_q     <= '0;
      seen_q    <= '0;
      upd_stb_q <= 1'b0;
      upd_idx_q <= '0;
      frame_q   <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      s_q       <= s_sync;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      bad_q     <= bad_d;
      seen_q    <= seen_d;
      upd_stb_q <= upd_stb_d;
      upd_idx_q <= upd_idx_d;
      frame_q   <= frame_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign hex_out     = hex_q;
  assign dp_out      = dp_q;
  assign valid       = valid_q;
  assign bad_pattern = bad_q;
  assign upd_stb     = upd_stb_q;
  assign upd_idx     = upd_idx_q;
  assign frame_stb   = frame_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder (4 digits, 4 stable samples, 2 sync stages).
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg_in;
  logic [3:0]  dig_sel;
  logic        clr;
  logic [15:0] hex_out;
  logic [3:0]  dp_out;
  logic [3:0]  valid;
  logic [3:0]  bad_pattern;
  logic        upd_stb;
  logic [1:0]  upd_idx;
  logic        frame_stb;
  logic        sel_err;

  int n_total = 0;
  int n_bad   = 0;
  int upd_cnt = 0;
  int frame_cnt = 0;
  int idx_log[$];

  always #5 clk = ~clk;

  seven_seg_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4),
    .SYNC_STAGES   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .clr         (clr),
    .hex_out     (hex_out),
    .dp_out      (dp_out),
    .valid       (valid),
    .bad_pattern (bad_pattern),
    .upd_stb     (upd_stb),
    .upd_idx     (upd_idx),
    .frame_stb   (frame_stb),
    .sel_err     (sel_err)
  );

  // Pulse monitor: settles 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      if (upd_stb === 1'b1) begin
        upd_cnt++;
        idx_log.push_back(int'(upd_idx));
      end
      if (frame_stb === 1'b1) frame_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [7:0] seg, input logic [3:0] dig, input int n);
    seg_in  = seg;
    dig_sel = dig;
    repeat (n) @(negedge clk);
  endtask

  function automatic int log_at(input int k);
    return (k < idx_log.size()) ? idx_log[k] : 99;
  endfunction

  int u0, f0, b0;

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    seg_in  = 8'h7E;
    dig_sel = 4'b0001;

    // 1: reset with an active bus, then full latency to the first commit
    repeat (5) @(negedge clk);
    check("rst_hex",   32'(hex_out),     32'h0);
    check("rst_dp",    32'(dp_out),      32'h0);
    check("rst_valid", 32'(valid),       32'h0);
    check("rst_bad",   32'(bad_pattern), 32'h0);
    check("rst_stb",   32'({upd_stb, frame_stb, sel_err}), 32'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("lat_early", 32'(upd_stb), 32'h0);
    @(negedge clk);
    check("lat_stb",   32'(upd_stb), 32'h1);
    check("lat_idx",   32'(upd_idx), 32'h0);
    check("lat_valid", 32'(valid),   32'h1);
    hold(8'h00, 4'b0000, 8);

    // 2: scan four digits
    u0 = upd_cnt; f0 = frame_cnt; b0 = idx_log.size();
    hold(8'h7E, 4'b0001, 6);
    hold(8'h30, 4'b0010, 6);
    hold(8'h6D, 4'b0100, 6);
    hold(8'h79, 4'b1000, 6);
    hold(8'h00, 4'b0000, 10);
    check("scan_hex",   32'(hex_out), 32'h3210);
    check("scan_valid", 32'(valid),   32'hF);
    check("scan_nupd",  32'(upd_cnt - u0), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("scan_idx%0d", k), 32'(log_at(b0 + k)), 32'(k));
    check("scan_frame", 32'(frame_cnt - f0), 32'd1);

    // 3: short glitch must not commit
    u0 = upd_cnt;
    hold(8'h7E, 4'b0001, 6);
    hold(8'h30, 4'b0001, 2);
    hold(8'h7E, 4'b0001, 6);
    hold(8'h00, 4'b0000, 10);
    check("glitch_hex",  32'(hex_out[3:0]), 32'h0);
    check("glitch_nupd", 32'(upd_cnt - u0), 32'd2);

    // 4: bad then blank on digit 2
    hold(8'h55, 4'b0100, 6);
    hold(8'h00, 4'b0000, 10);
    check("bad_flag",  32'(bad_pattern),    32'b0100);
    check("bad_valid", 32'(valid),          32'b1011);
    check("bad_hex",   32'(hex_out[11:8]),  32'h2);
    hold(8'h00, 4'b0100, 6);
    hold(8'h00, 4'b0000, 10);
    check("blank_flag",  32'(bad_pattern),   32'b0000);
    check("blank_valid", 32'(valid),         32'b1011);
    check("blank_hex",   32'(hex_out[11:8]), 32'h2);

    // 5: multi-hot select, blanking gap, clear
    u0 = upd_cnt;
    hold(8'h30, 4'b0011, 8);
    check("multi_err",  32'(sel_err), 32'h1);
    hold(8'h00, 4'b0000, 8);
    check("multi_nupd", 32'(upd_cnt - u0), 32'd0);
    check("gap_err",    32'(sel_err), 32'h1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_err",   32'(sel_err), 32'h0);
    check("clr_valid", 32'(valid),   32'h0);
    check("clr_hex",   32'(hex_out), 32'h3210);

    // 6: clr coinciding with a commit to digit 1
    hold(8'h7E, 4'b0001, 6);
    hold(8'h4E, 4'b1000, 6);
    hold(8'h00, 4'b0000, 10);
    check("pre6_valid", 32'(valid), 32'b1001);
    f0 = frame_cnt;
    seg_in  = 8'hFF;
    dig_sel = 4'b0010;
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("cc_stb",   32'(upd_stb),      32'h1);
    check("cc_valid", 32'(valid),        32'b0010);
    check("cc_dp",    32'(dp_out),       32'b0010);
    check("cc_hex",   32'(hex_out[7:4]), 32'h8);
    hold(8'hFF, 4'b0010, 3);
    hold(8'h00, 4'b0000, 8);
    hold(8'h3D, 4'b0001, 6);
    hold(8'h47, 4'b0100, 6);
    hold(8'h00, 4'b0000, 8);
    check("seen_noframe", 32'(frame_cnt - f0), 32'd0);
    hold(8'h5B, 4'b1000, 6);
    hold(8'h00, 4'b0000, 8);
    check("seen_frame", 32'(frame_cnt - f0), 32'd1);
    check("end_hex",    32'(hex_out),        32'h5F8D);
    check("end_valid",  32'(valid),          32'hF);
    check("end_bad",    32'(bad_pattern),    32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
